// File: rtl/enm_pkg.sv
// Shared enemy constants, HP/coordinate types and phase helpers for the HP and movement blocks.
package enm_pkg;

  localparam int NUM_ENM = 4;
  localparam int HP_W    = 7;
  localparam int CRD_W   = 10;

  localparam logic [HP_W-1:0]  PH1_TH       = 7'd80;
  localparam logic [HP_W-1:0]  PH2_TH       = 7'd40;
  localparam logic [HP_W-1:0]  HP_INIT      = 7'd120;
  localparam logic [HP_W-1:0]  DMG          = 7'd10;
  localparam logic [CRD_W-1:0] HIT_R        = 10'd12;
  localparam logic [7:0]       INVULN       = 8'd30;
  localparam logic [7:0]       REGEN_PERIOD = 8'd60;

  typedef logic [HP_W-1:0]  hp_t;
  typedef logic [CRD_W-1:0] crd_t;

  typedef enum logic [1:0] {
    PH_1,
    PH_2,
    PH_3
  } phase_e;

  function automatic phase_e phase_of(input hp_t hp);
    if (hp > PH1_TH) return PH_1;
    if (hp > PH2_TH) return PH_2;
    return PH_3;
  endfunction

  // Highest HP reachable by regen without leaving the current movement phase.
  function automatic hp_t phase_cap(input hp_t hp);
    case (phase_of(hp))
      PH_1:    return HP_INIT;
      PH_2:    return PH1_TH;
      default: return PH2_TH;
    endcase
  endfunction

  function automatic logic [CRD_W:0] abs_diff(input crd_t a, input crd_t b);
    logic signed [CRD_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/enm_hp_slot.sv
// One enemy's HP, hit-immunity cooldown and kill pulse.
// Optional HP regeneration is built only when ENM_REGEN_EN is defined.
module enm_hp_slot
  import enm_pkg::*;
(
  input  logic clk22,
  input  logic init,
  input  logic hit_accept_contact,
  output hp_t  hp,
  output logic kill
);

  logic [7:0] cooldown;
  logic       accept;
  hp_t        hp_after_hit;

  assign accept       = hit_accept_contact && (cooldown == 8'd0) && (hp != '0);
  assign hp_after_hit = (hp > DMG) ? hp - DMG : '0;

`ifdef ENM_REGEN_EN
  logic [7:0] regen_cnt;
  logic       regen_tick;

  assign regen_tick = (hp != '0) && (cooldown == 8'd0) && (regen_cnt == REGEN_PERIOD - 8'd1);

  // Regen time only accumulates while the enemy is alive and out of cooldown.
  always_ff @(posedge clk22) begin
    if (init) begin
      regen_cnt <= 8'd0;
    end else if (accept || regen_tick || (hp == '0) || (cooldown != 8'd0)) begin
      regen_cnt <= 8'd0;
    end else begin
      regen_cnt <= regen_cnt + 8'd1;
    end
  end
`endif

  // Cooldown is loaded one short so the hit cycle itself counts as the first immune cycle.
  always_ff @(posedge clk22) begin
    if (init) begin
      hp       <= HP_INIT;
      cooldown <= 8'd0;
      kill     <= 1'b0;
    end else begin
      kill <= accept && (hp_after_hit == '0);
      if (accept) begin
        cooldown <= INVULN - 8'd1;
      end else if (cooldown != 8'd0) begin
        cooldown <= cooldown - 8'd1;
      end
      if (accept) begin
        hp <= hp_after_hit;
      end
`ifdef ENM_REGEN_EN
      else if (regen_tick && (hp < phase_cap(hp))) begin
        hp <= hp + 7'd1;
      end
`endif
    end
  end

endmodule

// File: rtl/enm_hp_ctrl.sv
// Enemy HP controller: bullet contact detection, lowest-index priority, score and all-clear.
// Define ENM_REGEN_EN to build the per-enemy HP regeneration.
module enm_hp_ctrl
  import enm_pkg::*;
(
  input  logic             clk22,
  input  logic             rst,
  input  logic             gamestart,
  input  logic             hit_valid,
  input  logic [CRD_W-1:0] hit_x,
  input  logic [CRD_W-1:0] hit_y,
  input  logic [3:0]       enm_alive,
  input  logic [CRD_W-1:0] enmx1,
  input  logic [CRD_W-1:0] enmx2,
  input  logic [CRD_W-1:0] enmx3,
  input  logic [CRD_W-1:0] enmx4,
  input  logic [CRD_W-1:0] enmy1,
  input  logic [CRD_W-1:0] enmy2,
  input  logic [CRD_W-1:0] enmy3,
  input  logic [CRD_W-1:0] enmy4,
  output logic [HP_W-1:0]  enmhp1,
  output logic [HP_W-1:0]  enmhp2,
  output logic [HP_W-1:0]  enmhp3,
  output logic [HP_W-1:0]  enmhp4,
  output logic             hit_ack,
  output logic [3:0]       kill,
  output logic [9:0]       score,
  output logic             all_clear
);

  logic               init;
  crd_t               enm_x [NUM_ENM];
  crd_t               enm_y [NUM_ENM];
  hp_t                hp    [NUM_ENM];
  logic [NUM_ENM-1:0] contact;
  logic [NUM_ENM-1:0] sel;
  logic [NUM_ENM-1:0] kill_w;
  logic               all_zero;

  assign init = rst | gamestart;

  assign enm_x[0] = enmx1;
  assign enm_x[1] = enmx2;
  assign enm_x[2] = enmx3;
  assign enm_x[3] = enmx4;
  assign enm_y[0] = enmy1;
  assign enm_y[1] = enmy2;
  assign enm_y[2] = enmy3;
  assign enm_y[3] = enmy4;

  always_comb begin
    contact = '0;
    for (int i = 0; i < NUM_ENM; i++) begin
      contact[i] = hit_valid && enm_alive[i] && (hp[i] != '0)
                && (abs_diff(hit_x, enm_x[i]) < {1'b0, HIT_R})
                && (abs_diff(hit_y, enm_y[i]) < {1'b0, HIT_R});
    end
  end

  // Isolate the lowest set bit so one bullet can damage at most one enemy.
  assign sel = contact & (~contact + 4'd1);

  for (genvar i = 0; i < NUM_ENM; i++) begin : g_slot
    enm_hp_slot u_slot (
      .clk22              (clk22),
      .init               (init),
      .hit_accept_contact (sel[i]),
      .hp                 (hp[i]),
      .kill               (kill_w[i])
    );
  end

  assign enmhp1   = hp[0];
  assign enmhp2   = hp[1];
  assign enmhp3   = hp[2];
  assign enmhp4   = hp[3];
  assign kill     = kill_w;
  assign all_zero = (hp[0] == '0) && (hp[1] == '0) && (hp[2] == '0) && (hp[3] == '0);

  always_ff @(posedge clk22) begin
    if (init) begin
      hit_ack   <= 1'b0;
      score     <= 10'd0;
      all_clear <= 1'b0;
    end else begin
      hit_ack   <= |contact;
      all_clear <= all_clear | all_zero;
      if ((kill_w != '0) && (score != 10'h3FF)) begin
        score <= score + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_enm_hp_ctrl.sv
// Self-checking bench for enm_hp_ctrl: directed scenarios plus randomized play against a cycle model.
// The regen scenario is built only when ENM_REGEN_EN is defined.
module tb_enm_hp_ctrl;

  logic       clk22 = 1'b0;
  logic       rst, gamestart, hit_valid;
  logic [9:0] hit_x, hit_y;
  logic [3:0] enm_alive;
  logic [9:0] enmx1, enmx2, enmx3, enmx4, enmy1, enmy2, enmy3, enmy4;
  logic [6:0] enmhp1, enmhp2, enmhp3, enmhp4;
  logic       hit_ack, all_clear;
  logic [3:0] kill;
  logic [9:0] score;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: HP per enemy, cycle of last accepted hit, expected registered outputs.
  int         ex [4];
  int         ey [4];
  int         m_hp [4];
  int         m_last [4];
  int         m_cyc = 0;
  bit         m_ack;
  logic [3:0] m_kill;
  int         m_score;
  bit         m_clear;

  always #5 clk22 = ~clk22;

  assign enmx1 = 10'(ex[0]);
  assign enmx2 = 10'(ex[1]);
  assign enmx3 = 10'(ex[2]);
  assign enmx4 = 10'(ex[3]);
  assign enmy1 = 10'(ey[0]);
  assign enmy2 = 10'(ey[1]);
  assign enmy3 = 10'(ey[2]);
  assign enmy4 = 10'(ey[3]);

  enm_hp_ctrl dut (
    .clk22(clk22), .rst(rst), .gamestart(gamestart), .hit_valid(hit_valid),
    .hit_x(hit_x), .hit_y(hit_y), .enm_alive(enm_alive),
    .enmx1(enmx1), .enmx2(enmx2), .enmx3(enmx3), .enmx4(enmx4),
    .enmy1(enmy1), .enmy2(enmy2), .enmy3(enmy3), .enmy4(enmy4),
    .enmhp1(enmhp1), .enmhp2(enmhp2), .enmhp3(enmhp3), .enmhp4(enmhp4),
    .hit_ack(hit_ack), .kill(kill), .score(score), .all_clear(all_clear)
  );

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int dut_hp(input int i);
    case (i)
      0:       return int'(enmhp1);
      1:       return int'(enmhp2);
      2:       return int'(enmhp3);
      default: return int'(enmhp4);
    endcase
  endfunction

  // Drives one cycle of inputs, advances the model by the rules of the game, then waits past the edge.
  task automatic applyStimulus(input bit r, input bit gs, input bit hv, input int bx, input int by);
    bit allz;
    bit found;
    rst = r; gamestart = gs; hit_valid = hv;
    hit_x = 10'(bx); hit_y = 10'(by);
    if (r || gs) begin
      for (int i = 0; i < 4; i++) begin
        m_hp[i] = 120; m_last[i] = -100000;
      end
      m_ack = 0; m_kill = '0; m_score = 0; m_clear = 0;
    end else begin
      allz = 1;
      for (int i = 0; i < 4; i++) if (m_hp[i] != 0) allz = 0;
      if (m_kill != '0 && m_score < 1023) m_score++;
      m_clear = m_clear | allz;
      m_kill = '0; m_ack = 0; found = 0;
      for (int i = 0; i < 4; i++) begin
        if (!found && hv && enm_alive[i] && m_hp[i] > 0 &&
            iabs(bx - ex[i]) < 12 && iabs(by - ey[i]) < 12) begin
          found = 1;
          m_ack = 1;
          if (m_cyc - m_last[i] >= 30) begin
            m_hp[i] = (m_hp[i] > 10) ? m_hp[i] - 10 : 0;
            m_last[i] = m_cyc;
            if (m_hp[i] == 0) m_kill[i] = 1'b1;
          end
        end
      end
    end
    m_cyc++;
    @(posedge clk22);
    #1;
  endtask

  task automatic place_far();
    for (int i = 0; i < 4; i++) begin
      ex[i] = 500 + 100 * i; ey[i] = 900;
    end
    enm_alive = 4'hF;
  endtask

  task automatic test_reset();
    place_far();
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (dut_hp(i) !== 120) begin
        tests_failed++;
        $display("[TB] FAIL reset_hp%0d: got %0d expected 120", i + 1, dut_hp(i));
      end
    end
    tests_run++;
    if (score !== 10'd0) begin
      tests_failed++; $display("[TB] FAIL reset_score: got %0d expected 0", score);
    end
    tests_run++;
    if (all_clear !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_all_clear: got %0b expected 0", all_clear);
    end
    tests_run++;
    if (kill !== 4'b0) begin
      tests_failed++; $display("[TB] FAIL reset_kill: got %b expected 0000", kill);
    end
  endtask

  task automatic test_single_hit();
    place_far();
    applyStimulus(1, 0, 0, 0, 0);
    ex[0] = 40; ey[0] = 40;
    applyStimulus(0, 0, 1, 45, 35);
    tests_run++;
    if (enmhp1 !== 7'd110 || hit_ack !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_hit: got hp1=%0d ack=%0b expected hp1=110 ack=1", enmhp1, hit_ack);
    end
    tests_run++;
    if (enmhp2 !== 7'd120 || enmhp3 !== 7'd120 || enmhp4 !== 7'd120) begin
      tests_failed++;
      $display("[TB] FAIL single_hit_others: got %0d %0d %0d expected 120", enmhp2, enmhp3, enmhp4);
    end
    applyStimulus(0, 0, 0, 45, 35);
    tests_run++;
    if (hit_ack !== 1'b0 || enmhp1 !== 7'd110) begin
      tests_failed++;
      $display("[TB] FAIL single_hit_release: got ack=%0b hp1=%0d expected ack=0 hp1=110", hit_ack, enmhp1);
    end
  endtask

  task automatic test_cooldown();
    int ack_bad;
    place_far();
    applyStimulus(1, 0, 0, 0, 0);
    ex[0] = 40; ey[0] = 40;
    ack_bad = 0;
    for (int k = 0; k < 31; k++) begin
      applyStimulus(0, 0, 1, 45, 35);
      if (hit_ack !== 1'b1) ack_bad++;
    end
    tests_run++;
    if (ack_bad != 0) begin
      tests_failed++; $display("[TB] FAIL cooldown_ack: got %0d low cycles expected 0", ack_bad);
    end
    tests_run++;
    if (enmhp1 !== 7'd100) begin
      tests_failed++; $display("[TB] FAIL cooldown_hp: got %0d expected 100", enmhp1);
    end
  endtask

  task automatic test_priority();
    place_far();
    applyStimulus(1, 0, 0, 0, 0);
    ex[1] = 140; ey[1] = 80; ex[2] = 140; ey[2] = 80;
    applyStimulus(0, 0, 1, 141, 82);
    tests_run++;
    if (enmhp2 !== 7'd110 || enmhp3 !== 7'd120 || hit_ack !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL priority: got hp2=%0d hp3=%0d ack=%0b expected 110 120 1", enmhp2, enmhp3, hit_ack);
    end
  endtask

  // Kills each enemy in turn with a held bullet, then re-initialises with gamestart.
  task automatic test_kill_all();
    int kills [4];
    place_far();
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      kills[i] = 0;
      for (int k = 0; k < 331; k++) begin
        applyStimulus(0, 0, 1, ex[i] + 3, ey[i] - 2);
        if (kill[i] === 1'b1) kills[i]++;
      end
      applyStimulus(0, 0, 0, 0, 0);
      if (kill[i] === 1'b1) kills[i]++;
      applyStimulus(0, 0, 1, ex[i], ey[i]);
      tests_run++;
      if (kills[i] != 1 || dut_hp(i) !== 0 || hit_ack !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL kill%0d: got pulses=%0d hp=%0d ack=%0b expected 1 0 0", i + 1, kills[i], dut_hp(i), hit_ack);
      end
      tests_run++;
      if (score !== 10'(i + 1)) begin
        tests_failed++; $display("[TB] FAIL kill_score%0d: got %0d expected %0d", i + 1, score, i + 1);
      end
    end
    applyStimulus(0, 0, 0, 0, 0);
    tests_run++;
    if (all_clear !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL all_clear_set: got %0b expected 1", all_clear);
    end
    applyStimulus(0, 1, 0, 0, 0);
    tests_run++;
    if (enmhp1 !== 7'd120 || enmhp4 !== 7'd120 || score !== 10'd0 || all_clear !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL gamestart: got hp1=%0d hp4=%0d score=%0d clr=%0b expected 120 120 0 0",
               enmhp1, enmhp4, score, all_clear);
    end
  endtask

`ifdef ENM_REGEN_EN
  task automatic test_regen();
    place_far();
    applyStimulus(1, 0, 0, 0, 0);
    ex[0] = 40; ey[0] = 40;
    for (int k = 0; k < 121; k++) applyStimulus(0, 0, 1, 40, 40);
    for (int k = 0; k < 700; k++) applyStimulus(0, 0, 0, 0, 0);
    tests_run++;
    if (enmhp1 !== 7'd80) begin
      tests_failed++; $display("[TB] FAIL regen_cap: got %0d expected 80", enmhp1);
    end
    for (int k = 0; k < 200; k++) applyStimulus(0, 0, 0, 0, 0);
    tests_run++;
    if (enmhp1 !== 7'd80 || enmhp2 !== 7'd120) begin
      tests_failed++; $display("[TB] FAIL regen_hold: got %0d %0d expected 80 120", enmhp1, enmhp2);
    end
  endtask
`else
  // Randomized play against the model; enemies clustered so overlaps, cooldowns and kills all occur.
  task automatic test_random();
    int bad;
    int bx, by, t;
    place_far();
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ex[i] = 100 + int'($urandom_range(0, 30)); ey[i] = 100 + int'($urandom_range(0, 30));
    end
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        t = int'($urandom_range(0, 3));
        ex[t] = 100 + int'($urandom_range(0, 30)); ey[t] = 100 + int'($urandom_range(0, 30));
      end
      enm_alive = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      bx = 90 + int'($urandom_range(0, 50));
      by = 90 + int'($urandom_range(0, 50));
      applyStimulus(0, 0, ($urandom_range(0, 3) != 0), bx, by);
      bad = 0;
      for (int i = 0; i < 4; i++) if (dut_hp(i) !== m_hp[i]) bad = 1;
      tests_run++;
      if (bad != 0 || hit_ack !== m_ack || kill !== m_kill) begin
        tests_failed++;
        $display("[TB] FAIL random_cyc%0d: got hp=%0d,%0d,%0d,%0d ack=%0b kill=%b expected hp=%0d,%0d,%0d,%0d ack=%0b kill=%b",
                 k, enmhp1, enmhp2, enmhp3, enmhp4, hit_ack, kill,
                 m_hp[0], m_hp[1], m_hp[2], m_hp[3], m_ack, m_kill);
      end
      tests_run++;
      if (score !== 10'(m_score) || all_clear !== m_clear) begin
        tests_failed++;
        $display("[TB] FAIL random_score_cyc%0d: got score=%0d clr=%0b expected score=%0d clr=%0b",
                 k, score, all_clear, m_score, m_clear);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; gamestart = 1'b0; hit_valid = 1'b0;
    hit_x = '0; hit_y = '0; enm_alive = 4'hF;
    place_far();
    test_reset();
    test_single_hit();
    test_cooldown();
    test_priority();
    test_kill_all();
`ifdef ENM_REGEN_EN
    test_regen();
`else
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/enm_hp_ctrl.md
Name: enm_hp_ctrl

Overview:
Owns the hit points of the four enemies and produces the enmhp1..enmhp4 buses that the enemy-movement block reads. Each cycle it checks the current player-bullet position against the four enemy positions and alive flags, applies damage with a per-enemy invulnerability window, and generates kill pulses. It also maintains a score counter and an all-clear flag for the game-flow FSM. Sits between bullet logic and the enemy-movement block.

Parameters:
HP_INIT, 7'd120, starting HP; above 80 so every enemy begins in movement phase 1
DMG, 7'd10, HP removed per accepted hit
HIT_R, 10'd12, collision half-window in pixels, per axis
INVULN, 8'd30, clk22 cycles of hit immunity after an accepted hit
REGEN_PERIOD, 8'd60, cycles between regen ticks (ENM_REGEN_EN only)

Ports:
clk22  in  1  game clock
rst  in  1  synchronous, active-high reset
gamestart  in  1  synchronous re-initialise; same effect as rst
hit_valid  in  1  bullet position valid this cycle
hit_x  in  10  bullet x
hit_y  in  10  bullet y
enm_alive  in  4  alive flags, bit i = enemy i+1
enmx1..enmx4  in  10 each  enemy x positions
enmy1..enmy4  in  10 each  enemy y positions
enmhp1..enmhp4  out  7 each  registered enemy HP
hit_ack  out  1  one-cycle pulse: bullet contacted an alive enemy; bullet logic removes the bullet
kill  out  4  one-cycle pulse per enemy when its HP reaches 0
score  out  10  kills since reset, saturating
all_clear  out  1  all four HP equal 0

Behaviour:
- Reset (rst or gamestart, sampled at posedge clk22): enmhp1..4 = HP_INIT; cooldowns = 0; regen counters = 0; hit_ack = 0; kill = 0; score = 0; all_clear = 0. Reset wins over every other event in the same cycle.
- Contact for enemy i: hit_valid, enm_alive[i], and enmhp_i > 0, with |hit_x - enmx_i| < HIT_R and |hit_y - enmy_i| < HIT_R.
  - Compute differences as 11-bit signed values.
- Priority: if several enemies are in contact, only the lowest index is considered. One bullet damages at most one enemy.
- Latency: contact sampled in cycle N; enmhp, hit_ack and kill update at the N+1 edge and are visible during cycle N+1.
- Accepted hit: contact on the selected enemy and its cooldown = 0.
  - HP becomes HP - DMG, saturating at 0.
  - Cooldown loads INVULN.
- Contact during cooldown: hit_ack still pulses and HP is unchanged.
- Cooldown decrements by 1 per cycle while nonzero.
- kill[i] pulses for exactly one cycle on the 1->0 HP transition.
  - score increments by 1 per kill, saturating at 1023.
  - Simultaneous kills are impossible because only one hit is accepted per cycle.
- HP never increases except on reset or via regen; an HP of 0 is final until reset.
- all_clear: registered, equals 1 when all four HP are 0, holds until reset.
- hit_valid low: no hit_ack. Cooldowns continue counting.

Optional Feature:
ENM_REGEN_EN:
- Defined:
  - Each alive enemy (HP > 0) with cooldown = 0 gains 1 HP every REGEN_PERIOD cycles.
  - HP is capped at the top of its current phase band: 40 if HP <= 40, 80 if HP <= 80, otherwise HP_INIT. HP never crosses back over 40 or 80, so the movement phase is monotonic.
  - The regen counter clears on every accepted hit.
  - If an accepted hit and a regen tick fall in the same cycle, the hit wins and no regen is applied.
- Undefined: no regen logic, and the REGEN_PERIOD counters are not synthesised.

Decomposition:
- Package enm_pkg:
  - NUM_ENM = 4.
  - HP width 7, coordinate width 10.
  - Phase thresholds PH1_TH = 7'd80 and PH2_TH = 7'd40.
  - HP_INIT default.
  - These are shared with the enemy-movement block.
- Sub-module enm_hp_slot, instantiated four times:
  - Holds HP, cooldown, the optional regen counter, and kill-pulse generation.
  - Inputs: a single hit_accept_contact strobe.
- Top level holds the contact comparators, priority select, score and all_clear.

Test Plan:
- Reset then idle 10 cycles -> enmhp1..4 = 120, score = 0, all_clear = 0, kill = 0.
- Enemy1 at (40,40); bullet (45,35) with hit_valid for 1 cycle -> next cycle enmhp1 = 110, hit_ack = 1 for one cycle; other HP unchanged.
- Same bullet held valid 31 cycles -> hits accepted at cycle 0 and cycle 30 only; enmhp1 = 100; hit_ack high every cycle after the first.
- Bullet overlapping enemy2 (140,80) and enemy3 (140,80) -> only enmhp2 decrements.
- Enemy with HP = 5 takes a hit -> HP = 0, kill bit pulses once, score +1; further contacts give no hit_ack.
- Kill all four, then gamestart -> all_clear was 1; after gamestart, HP = 120, score = 0, all_clear = 0.
- ENM_REGEN_EN: HP = 75, no hits, 60*10 cycles -> HP = 80 and holds at 80.
